// File: rtl/result_streamer.sv
// result_streamer
//   Reads 32-bit records from result RAM and serializes each one into four
//   bytes, MSB first, for the byte transmitter. After the last record it
//   sends a single 0x00 terminator byte and pulses done.
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   start           one-cycle pulse that begins a transfer (sampled in IDLE only)
//   recCount        number of records to send, latched when start is accepted
//   memRen/memAddr  RAM read port request (read latency is 1 cycle)
//   memData         RAM read data, valid the cycle after memRen
//   txByte/txValid  byte offered to the transmitter
//   txReady         transmitter accepts; a transfer is txValid & txReady
//   busy            high in every state except IDLE
//   done            one-cycle pulse after the terminator byte is accepted
module result_streamer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] recCount,
  output logic              memRen,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [31:0]       memData,
  output logic [7:0]        txByte,
  output logic              txValid,
  input  logic              txReady,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, TERM, FIN} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] count, count_d;
  logic [ADDR_W-1:0] addr, addr_d, addr_inc;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [1:0]        byte_idx, byte_idx_d;
  logic [31:0]       shreg, shreg_d;
  logic              mem_ren_d, tx_valid_d, busy_d, done_d;
  logic [7:0]        tx_byte_d;
  logic              xfer;

  assign xfer     = txValid & txReady;
  // Wraps only for a count that was already exhausted, so no extra bit needed.
  assign addr_inc = addr + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Every output is computed one cycle ahead here and registered below.
  always_comb begin
    state_d    = state;
    count_d    = count;
    addr_d     = addr;
    byte_idx_d = byte_idx;
    shreg_d    = shreg;
    mem_ren_d  = 1'b0;
    mem_addr_d = memAddr;
    tx_valid_d = txValid;
    tx_byte_d  = txByte;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          count_d = recCount;
          addr_d  = '0;
          if (recCount == '0) begin
            state_d    = TERM;
            tx_valid_d = 1'b1;
            tx_byte_d  = 8'h00;
          end else begin
            state_d    = FETCH;
            mem_ren_d  = 1'b1;
            mem_addr_d = '0;
          end
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shreg_d    = memData;
        byte_idx_d = 2'd0;
        tx_valid_d = 1'b1;
        tx_byte_d  = memData[31:24];
        state_d    = SEND;
      end
      SEND: begin
        if (xfer) begin
          shreg_d    = shreg << 8;
          byte_idx_d = byte_idx + 2'd1;
          tx_byte_d  = shreg[23:16];
          if (byte_idx == 2'd3) begin
            if (addr_inc == count) begin
              state_d   = TERM;
              tx_byte_d = 8'h00;
            end else begin
              // Fetch the next record; txValid drops for FETCH and LOAD.
              addr_d     = addr_inc;
              mem_ren_d  = 1'b1;
              mem_addr_d = addr_inc;
              tx_valid_d = 1'b0;
              state_d    = FETCH;
            end
          end
        end
      end
      TERM: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      addr     <= '0;
      byte_idx <= 2'd0;
      shreg    <= '0;
      memRen   <= 1'b0;
      memAddr  <= '0;
      txByte   <= 8'h00;
      txValid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      addr     <= addr_d;
      byte_idx <= byte_idx_d;
      shreg    <= shreg_d;
      memRen   <= mem_ren_d;
      memAddr  <= mem_addr_d;
      txByte   <= tx_byte_d;
      txValid  <= tx_valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer
//   Drives result_streamer with directed and randomized transfers against a
//   RAM model. The expected stream is built from the record list (4 bytes per
//   record, MSB first, then 0x00) and compared with the bytes actually
//   accepted on the TX side.
module tb_result_streamer;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] recCount;
  logic              memRen;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memData = '0;
  logic [7:0]        txByte;
  logic              txValid;
  logic              txReady;
  logic              busy;
  logic              done;

  logic [31:0] mem [256];
  int n_chk = 0;
  int n_pass = 0;

  result_streamer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .recCount(recCount),
    .memRen(memRen), .memAddr(memAddr), .memData(memData),
    .txByte(txByte), .txValid(txValid), .txReady(txReady),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One-cycle read latency RAM.
  always @(posedge clk) if (memRen) memData <= mem[memAddr[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles while 0xCC offered
  task automatic run(input int n, input int mode, input bit restart, input bit abort);
    logic [7:0] exp_b[$];
    logic [7:0] got_b[$];
    int exp_a[$];
    int got_a[$];
    int first_ren = -1, first_v = -1, busy_cnt = 0, done_cnt = 0, done_k = -1;
    int stall = 0;
    bit pend = 0;
    logic [7:0] pend_b = 8'h00;
    int k = 0;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(i);
      for (int j = 3; j >= 0; j--) exp_b.push_back(mem[i][8*j +: 8]);
    end
    exp_b.push_back(8'h00);

    @(negedge clk);
    start = 1'b1;
    recCount = ADDR_W'(n);
    txReady = (mode != 1);
    forever begin
      @(negedge clk);
      k++;
      start = restart && (k == 6);
      recCount = ADDR_W'($urandom);
      if (pend) begin
        chk("hold_valid", {31'd0, txValid}, 32'd1);
        chk("hold_byte", {24'd0, txByte}, {24'd0, pend_b});
        pend = 0;
      end
      if (memRen) begin
        got_a.push_back(int'(memAddr));
        if (first_ren < 0) first_ren = k;
      end
      if (txValid && first_v < 0) first_v = k;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (abort && got_b.size() == 2 && txValid) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_txValid", {31'd0, txValid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_memAddr", {16'd0, memAddr}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_memRen", {31'd0, memRen}, 32'd0);
        return;
      end
      case (mode)
        1: txReady = ($urandom_range(0, 3) != 0);
        2: begin
          if (txValid && txByte == 8'hCC && stall < 5) begin
            txReady = 1'b0;
            stall++;
          end else txReady = 1'b1;
        end
        default: txReady = 1'b1;
      endcase
      if (txValid && txReady) got_b.push_back(txByte);
      else if (txValid) begin
        pend = 1;
        pend_b = txByte;
      end
      if (done_k >= 0 && k >= done_k + 2) break;
      if (k > 3000) begin
        chk("timeout", 32'd1, 32'd0);
        break;
      end
    end
    txReady = 1'b0;

    chk("first_ren", 32'(first_ren), (n == 0) ? 32'hFFFF_FFFF : 32'd1);
    chk("first_valid", 32'(first_v), (n == 0) ? 32'd1 : 32'd3);
    chk("done_cnt", 32'(done_cnt), 32'd1);
    if (mode == 0) chk("busy_cycles", 32'(busy_cnt), (n == 0) ? 32'd2 : 32'(6*n + 2));
    if (mode == 2) chk("stall_cnt", 32'(stall), 32'd5);
    chk("nbytes", 32'(got_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      chk($sformatf("byte%0d", i), {24'd0, got_b[i]}, {24'd0, exp_b[i]});
    chk("naddr", 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      chk($sformatf("addr%0d", i), 32'(got_a[i]), 32'(exp_a[i]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 1'b1;
    start = 1'b0;
    recCount = '0;
    txReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_memRen", {31'd0, memRen}, 32'd0);
    chk("rst_memAddr", {16'd0, memAddr}, 32'd0);
    chk("rst_txByte", {24'd0, txByte}, 32'd0);
    chk("rst_txValid", {31'd0, txValid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    mem[0] = 32'h1234_5678;
    run(1, 0, 0, 0);
    run(0, 0, 0, 0);
    mem[0] = 32'hAABB_CCDD;
    run(1, 2, 0, 0);
    mem[0] = 32'h0000_0001;
    mem[1] = 32'h0000_FF00;
    mem[2] = 32'h8000_0000;
    run(3, 0, 0, 0);
    mem[0] = 32'h1234_5678;
    run(1, 0, 1, 0);
    run(2, 0, 0, 1);
    run(2, 0, 0, 0);
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      run($urandom_range(1, 6), 1, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
